// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants for the CLA adder datapath and its result FIFO
// Purpose: adder width, signed saturation limits and result-entry bit layout.
// Ports: none (package).
package adder_pkg;

    localparam int ADD_WIDTH = 32;

    localparam logic [ADD_WIDTH-1:0] SAT_POS_MAX = 32'h7FFF_FFFF;
    localparam logic [ADD_WIDTH-1:0] SAT_NEG_MIN = 32'h8000_0000;

    // Entry layout: {overflow, cout, sum}
    localparam int COUT_BIT = ADD_WIDTH;
    localparam int OVF_BIT  = ADD_WIDTH + 1;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - generic synchronous FIFO with flush and masked read data
// Purpose: DEPTH-entry FIFO, no fall-through, flush has priority over push/pop.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   push_i, pop_i       requests; ignored when full / empty respectively
//   flush_i             synchronous clear of pointers and count
//   wdata_i             entry written on push
//   rdata_o             head entry, forced to 0 when empty
//   count_o             occupancy, full_o / empty_o decoded from it
module sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

    // A full FIFO refuses pushes even when a pop happens the same cycle.
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by natural overflow.
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until count says so.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/adder_result_fifo.sv
// rtl/adder_result_fifo.sv - buffers CLA adder results behind a valid/ready handshake
// Purpose: queues {overflow, cout, S} per accepted result and keeps a saturating
//   count of overflowed results. Optional macro ADDER_RESULT_SATURATE_EN clamps
//   the stored sum to the signed limit on overflow.
// Ports:
//   Clk, Rst_n                       clock, asynchronous active-low reset
//   in_valid/in_ready, S/cout/overflow   upstream result handshake and payload
//   flush                            synchronous clear of queued entries
//   out_valid/out_ready              downstream handshake
//   out_sum/out_cout/out_ovf         head entry, 0 when empty
//   count                            occupancy
//   ovf_count                        saturating count of accepted overflow results
module adder_result_fifo
    import adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         S,
    input  logic                     cout,
    input  logic                     overflow,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_sum,
    output logic                     out_cout,
    output logic                     out_ovf,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         ovf_count
);

    localparam int ENTRY_W  = WIDTH + 2;
    localparam int COUT_POS = WIDTH + (COUT_BIT - ADD_WIDTH);
    localparam int OVF_POS  = WIDTH + (OVF_BIT - ADD_WIDTH);

    logic               push, pop;
    logic               full, empty;
    logic [WIDTH-1:0]   sum_store;
    logic [ENTRY_W-1:0] wdata, rdata;
    logic [CNT_W-1:0]   ovf_count_q, ovf_count_d;

    // Handshakes depend only on the registered count.
    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

`ifdef ADDER_RESULT_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // A set sign bit on overflow means two positives wrapped negative.
    assign sum_store = overflow ? (S[WIDTH-1] ? SAT_POS : SAT_NEG) : S;
`else
    assign sum_store = S;
`endif

    always_comb begin
        wdata               = '0;
        wdata[WIDTH-1:0]    = sum_store;
        wdata[COUT_POS]     = cout;
        wdata[OVF_POS]      = overflow;
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_ni  (Rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign out_sum  = rdata[WIDTH-1:0];
    assign out_cout = rdata[COUT_POS];
    assign out_ovf  = rdata[OVF_POS];

    // A push dropped by flush must not be counted.
    always_comb begin
        ovf_count_d = ovf_count_q;
        if (push && !flush && overflow && !(&ovf_count_q))
            ovf_count_d = ovf_count_q + CNT_W'(1);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) ovf_count_q <= '0;
        else        ovf_count_q <= ovf_count_d;
    end

    assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_adder_result_fifo.sv
// tb/tb_adder_result_fifo.sv - directed self-checking bench for adder_result_fifo
module tb_adder_result_fifo;
    import adder_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] S;
    logic        cout;
    logic        overflow;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic [2:0]  count;
    logic [15:0] ovf_count;

    int n_pass  = 0;
    int n_total = 0;

    adder_result_fifo #(.WIDTH(32), .DEPTH(4), .CNT_W(16)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .cout      (cout),
        .overflow  (overflow),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .count     (count),
        .ovf_count (ovf_count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Inputs change at the falling edge; outputs are sampled there too.
    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic push_one(input logic [31:0] s, input logic c, input logic o);
        in_valid = 1'b1; S = s; cout = c; overflow = o;
        step();
        in_valid = 1'b0;
    endtask

    logic [31:0] exp_a, exp_b;

    initial begin
        Rst_n = 1'b0; in_valid = 1'b0; S = '0; cout = 1'b0; overflow = 1'b0;
        flush = 1'b0; out_ready = 1'b0;
        step(); step();
        Rst_n = 1'b1;
        step();

        // Reset / idle
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_ovf_count", 64'(ovf_count), 64'd0);

        // Single push, one-cycle latency, then pop
        push_one(32'h5, 1'b0, 1'b0);
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_sum", 64'(out_sum), 64'h5);
        chk("single_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("single_pop_count", 64'(count), 64'd0);
        chk("single_pop_sum", 64'(out_sum), 64'd0);

        // Fill, refuse fifth, drain in order; three rounds wrap the pointers
        for (int r = 0; r < 3; r++) begin
            for (int i = 1; i <= 4; i++)
                push_one(32'(r * 16 + i), i[0], 1'b0);
            chk("fill_in_ready", 64'(in_ready), 64'd0);
            chk("fill_count", 64'(count), 64'd4);
            push_one(32'(r * 16 + 5), 1'b0, 1'b0);
            chk("refuse_count", 64'(count), 64'd4);
            out_ready = 1'b1;
            for (int i = 1; i <= 4; i++) begin
                chk("drain_sum", 64'(out_sum), 64'(r * 16 + i));
                chk("drain_cout", 64'(out_cout), 64'(i[0]));
                step();
            end
            out_ready = 1'b0;
            chk("drain_empty", 64'(count), 64'd0);
        end

        // Full with simultaneous in_valid and out_ready: pop only
        for (int i = 0; i < 4; i++)
            push_one(32'hA0 + 32'(i), 1'b0, 1'b0);
        in_valid = 1'b1; S = 32'hFF; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("full_pop_count", 64'(count), 64'd3);
        chk("full_pop_in_ready", 64'(in_ready), 64'd1);
        for (int i = 1; i < 4; i++) begin
            chk("full_pop_drain", 64'(out_sum), 64'(32'hA0 + 32'(i)));
            step();
        end
        out_ready = 1'b0;
        chk("full_pop_empty", 64'(count), 64'd0);

        // Overflow capture: positive wrap then negative wrap
`ifdef ADDER_RESULT_SATURATE_EN
        exp_a = SAT_POS_MAX;
        exp_b = SAT_NEG_MIN;
`else
        exp_a = 32'h8000_0000;
        exp_b = 32'h7FFF_FFFF;
`endif
        push_one(32'h8000_0000, 1'b0, 1'b1);
        chk("ovf_pos_sum", 64'(out_sum), 64'(exp_a));
        chk("ovf_pos_flag", 64'(out_ovf), 64'd1);
        chk("ovf_pos_cout", 64'(out_cout), 64'd0);
        chk("ovf_count_1", 64'(ovf_count), 64'd1);
        push_one(32'h7FFF_FFFF, 1'b1, 1'b1);
        chk("ovf_count_2", 64'(ovf_count), 64'd2);
        chk("ovf_two_count", 64'(count), 64'd2);
        out_ready = 1'b1;
        step();
        chk("ovf_neg_sum", 64'(out_sum), 64'(exp_b));
        chk("ovf_neg_flag", 64'(out_ovf), 64'd1);
        chk("ovf_neg_cout", 64'(out_cout), 64'd1);
        step();
        out_ready = 1'b0;
        chk("ovf_drained", 64'(count), 64'd0);

        // Flush with three entries and a concurrent overflow push
        push_one(32'h11, 1'b0, 1'b0);
        push_one(32'h22, 1'b0, 1'b0);
        push_one(32'h33, 1'b0, 1'b0);
        chk("pre_flush_count", 64'(count), 64'd3);
        in_valid = 1'b1; S = 32'h44; overflow = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; overflow = 1'b0; flush = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_ovf_count", 64'(ovf_count), 64'd2);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_out_sum", 64'(out_sum), 64'd0);
        push_one(32'h55, 1'b0, 1'b0);
        chk("post_flush_sum", 64'(out_sum), 64'h55);
        chk("post_flush_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Asynchronous reset mid-drain
        push_one(32'h1, 1'b0, 1'b1);
        push_one(32'h2, 1'b0, 1'b0);
        push_one(32'h3, 1'b0, 1'b0);
        out_ready = 1'b1;
        step();
        chk("mid_drain_sum", 64'(out_sum), 64'h2);
        #1;
        Rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_sum", 64'(out_sum), 64'd0);
        chk("arst_out_ovf", 64'(out_ovf), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_ovf_count", 64'(ovf_count), 64'd0);
        out_ready = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/adder_result_fifo.md
Name: adder_result_fifo

Overview:
- Downstream stage of the 32-bit signed CLA adder.
- Captures each adder result (sum, carry-out, signed-overflow flag) into a small synchronous FIFO behind a valid/ready handshake, so the consumer can stall without losing results.
- Keeps a saturating count of overflowed results for the team's characterisation runs.
- Sits between the adder outputs and the result sink or readback logic.

Parameters:
- WIDTH, 32, sum width; matches the adder datapath.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- CNT_W, 16, width of the overflow event counter.

Ports:
- Clk  in  1  single clock; all state updates on its rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  adder result on S/cout/overflow is valid this cycle.
- in_ready  out  1  FIFO can accept; equals (count != DEPTH).
- S  in  WIDTH  signed sum from the adder.
- cout  in  1  adder carry-out.
- overflow  in  1  adder signed-overflow flag.
- flush  in  1  synchronous clear of FIFO contents.
- out_valid  out  1  head entry present; equals (count != 0).
- out_ready  in  1  consumer accepts the head entry.
- out_sum  out  WIDTH  head entry sum; 0 when empty.
- out_cout  out  1  head entry carry; 0 when empty.
- out_ovf  out  1  head entry overflow flag; 0 when empty.
- count  out  $clog2(DEPTH)+1  current occupancy.
- ovf_count  out  CNT_W  accepted entries with overflow=1; saturates at all-ones.

Behaviour:
- Reset (Rst_n low, asynchronous): pointers, count and ovf_count go to 0. Outputs after reset: in_ready=1, out_valid=0, out_sum/out_cout/out_ovf=0. Reset mid-operation discards all entries immediately.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Storage: entry = {overflow, cout, S}, written at wr_ptr. Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Latency: no fall-through. An entry pushed in cycle N appears at the outputs in cycle N+1, even when the FIFO was empty.
- Output ordering: outputs show the entry at rd_ptr, combinationally masked to 0 when count==0.
- Simultaneous push and pop with 0<count<DEPTH: both occur and count is unchanged.
- Full (count==DEPTH): in_ready=0. A push is refused even if a pop occurs the same cycle; there is no full-bypass. in_valid while full is ignored, and the upstream must hold the data.
- Empty: a pop is impossible, since out_valid=0.
- flush (synchronous): takes priority over push and pop in the same cycle. Pointers and count go to 0; ovf_count is not affected; any push in that cycle is dropped.
- ovf_count: increments by 1 on each push with overflow=1 and holds at 2^CNT_W-1. Only an asynchronous reset clears it.
- Handshake outputs in_ready and out_valid are derived from the count register only, with no combinational path from inputs.

Optional Feature:
- Macro ADDER_RESULT_SATURATE_EN.
- Defined: on push with overflow=1, the stored sum is clamped to the true-signed limit. If S[WIDTH-1]=1 (positive overflow), store 0x7FFFFFFF; if S[WIDTH-1]=0 (negative overflow), store 0x80000000. The stored ovf flag and cout are unchanged.
- Undefined: raw S is stored unmodified.

Decomposition:
- Shared package adder_pkg holds: ADD_WIDTH=32, SAT_POS_MAX (0x7FFFFFFF), SAT_NEG_MIN (0x80000000), and the entry layout bit positions (OVF_BIT, COUT_BIT).
- One natural sub-module, sync_fifo: generic WIDTH/DEPTH FIFO with push/pop/flush/count and masked read data.
- adder_result_fifo wraps sync_fifo and adds the saturation mux and ovf_count.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, count=0, out_sum=0, ovf_count=0.
- Push S=0x00000005, cout=0, ovf=0 with out_ready=0 -> next cycle out_valid=1, out_sum=0x00000005, count=1. Pop -> count=0, out_sum=0.
- Push 4 entries (1,2,3,4) with out_ready=0, then a 5th (5) -> in_ready=0 after the 4th and the 5th is not accepted. Drain yields 1,2,3,4 in order. Repeat twice to exercise pointer wrap.
- Full FIFO with in_valid=1 and out_ready=1 -> one pop and no push; count goes from 4 to 3, then in_ready=1 the following cycle.
- Push S=0x80000000, overflow=1 (0x7FFFFFFF+1) -> with ADDER_RESULT_SATURATE_EN out_sum=0x7FFFFFFF, otherwise 0x80000000. In both builds out_ovf=1 and ovf_count=1.
- flush with 3 entries and a simultaneous push -> next cycle count=0 and ovf_count is unchanged. Separately, assert Rst_n low mid-drain -> outputs go to 0 immediately, without waiting for a clock edge.
